// File: rtl/dcache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl_pkg
// Brief    : Shared state encoding and address-split helpers for the D-cache.
// Revision : 1.0
// ============================================================================
package dcache_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COMPARE   = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_ALLOCATE  = 3'd3,
        ST_FLUSH     = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    function automatic int calc_offset_w(input int block_w);
        return $clog2(block_w / 8);
    endfunction

    function automatic int calc_index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int calc_tag_w(input int word_w, input int block_w, input int lines);
        return word_w - calc_offset_w(block_w) - calc_index_w(lines);
    endfunction

    localparam int c_dflt_offset_w = calc_offset_w(128);
    localparam int c_dflt_index_w  = calc_index_w(16);
    localparam int c_dflt_tag_w    = calc_tag_w(32, 128, 16);

endpackage
`default_nettype wire

// File: rtl/dcache_ctrl_array.sv
`default_nettype none
// ============================================================================
// Module   : dcache_array
// Brief    : Tag/valid/dirty/data storage, one async read port, one write port.
// Revision : 1.0
// ============================================================================
module dcache_array
    import dcache_ctrl_pkg::*;
#(
    parameter int TAG_W   = c_dflt_tag_w,
    parameter int INDEX_W = c_dflt_index_w,
    parameter int BLOCK_W = 128,
    parameter int LINES   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic               o_rd_valid,
    output logic               o_rd_dirty,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [BLOCK_W-1:0] o_rd_data,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  logic               i_wr_valid,
    input  logic               i_wr_dirty,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [BLOCK_W-1:0] i_wr_data
);

    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [BLOCK_W-1:0] r_data [LINES];

    // Only the status bits are reset; tag/data stay RAM-friendly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= i_wr_valid;
            r_dirty[i_wr_idx] <= i_wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Brief    : Direct-mapped write-back/write-allocate D-cache with halt flush.
//            Optional hit/miss counters when DCACHE_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int LINES   = 16,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [WORD_W-1:0]  cpu_addr,
    input  logic [WORD_W-1:0]  cpu_wdata,
    output logic [WORD_W-1:0]  cpu_rdata,
    output logic               cpu_ready,
    input  logic               halt,
    output logic [WORD_W-1:0]  mem_addr,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    output logic               mem_flush,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
);

    localparam int c_offset_w = calc_offset_w(BLOCK_W);
    localparam int c_index_w  = calc_index_w(LINES);
    localparam int c_tag_w    = calc_tag_w(WORD_W, BLOCK_W, LINES);
    localparam int c_wsel_w   = c_offset_w - 2;
    localparam int c_cnt_w    = $clog2(MEM_LAT + 1);

    localparam logic [c_cnt_w-1:0]   c_cnt_init = c_cnt_w'(MEM_LAT - 1);
    localparam logic [c_index_w-1:0] c_last_idx = c_index_w'(LINES - 1);

    state_t                r_state;
    logic [c_tag_w-1:0]    r_tag;
    logic [c_index_w-1:0]  r_idx;
    logic [c_wsel_w-1:0]   r_wsel;
    logic                  r_we;
    logic [WORD_W-1:0]     r_wdata;
    logic [WORD_W-1:0]     r_mem_addr;
    logic                  r_mem_rd;
    logic                  r_mem_wr;
    logic [BLOCK_W-1:0]    r_mem_wdata;
    logic                  r_mem_flush;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_index_w-1:0]  r_ptr;
    logic                  r_flushing;
    logic                  r_refilled;

    logic [c_tag_w-1:0]    w_cpu_tag;
    logic [c_index_w-1:0]  w_cpu_idx;
    logic [c_index_w-1:0]  w_rd_idx;
    logic                  w_rd_valid;
    logic                  w_rd_dirty;
    logic [c_tag_w-1:0]    w_rd_tag;
    logic [BLOCK_W-1:0]    w_rd_data;
    logic                  w_hit;
    logic                  w_acc_victim;
    logic [WORD_W-1:0]     w_word;
    logic [BLOCK_W-1:0]    w_store_line;
    logic                  w_we;
    logic [c_index_w-1:0]  w_wr_idx;
    logic                  w_wr_dirty;
    logic [c_tag_w-1:0]    w_wr_tag;
    logic [BLOCK_W-1:0]    w_wr_data;
    logic                  w_unused;

    assign w_cpu_tag = cpu_addr[WORD_W-1 -: c_tag_w];
    assign w_cpu_idx = cpu_addr[c_offset_w +: c_index_w];
    assign w_unused  = ^{cpu_addr[1:0], r_refilled};

    // The single read port looks up the incoming address while idle so the
    // writeback address is already on mem_addr when the strobe rises.
    always_comb begin
        w_rd_idx = r_idx;
        if (r_state == ST_IDLE) begin
            w_rd_idx = w_cpu_idx;
        end else if (r_flushing) begin
            w_rd_idx = r_ptr;
        end
    end

    dcache_array #(
        .TAG_W   (c_tag_w),
        .INDEX_W (c_index_w),
        .BLOCK_W (BLOCK_W),
        .LINES   (LINES)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_rd_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_dirty (w_rd_dirty),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_we       (w_we),
        .i_wr_idx   (w_wr_idx),
        .i_wr_valid (1'b1),
        .i_wr_dirty (w_wr_dirty),
        .i_wr_tag   (w_wr_tag),
        .i_wr_data  (w_wr_data)
    );

    assign w_hit        = w_rd_valid && (w_rd_tag == r_tag);
    assign w_acc_victim = w_rd_valid && w_rd_dirty && (w_rd_tag != w_cpu_tag);

    // Word 0 sits in the most significant bits of the line.
    assign w_word = w_rd_data[BLOCK_W-1-int'(r_wsel)*WORD_W -: WORD_W];

    always_comb begin
        w_store_line = w_rd_data;
        w_store_line[BLOCK_W-1-int'(r_wsel)*WORD_W -: WORD_W] = r_wdata;
    end

    always_comb begin
        w_we       = 1'b0;
        w_wr_idx   = r_idx;
        w_wr_dirty = 1'b0;
        w_wr_tag   = r_tag;
        w_wr_data  = mem_rdata;
        case (r_state)
            ST_COMPARE: begin
                if (w_hit && r_we) begin
                    w_we       = 1'b1;
                    w_wr_dirty = 1'b1;
                    w_wr_data  = w_store_line;
                end
            end
            ST_ALLOCATE: begin
                w_we = r_mem_rd && (r_cnt == '0);
            end
            ST_WRITEBACK: begin
                // Flush writebacks only clear dirty; tag and data are kept.
                if (r_flushing && r_mem_wr && (r_cnt == '0)) begin
                    w_we      = 1'b1;
                    w_wr_idx  = r_ptr;
                    w_wr_tag  = w_rd_tag;
                    w_wr_data = w_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tag       <= '0;
            r_idx       <= '0;
            r_wsel      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_flush <= 1'b0;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_flushing  <= 1'b0;
            r_refilled  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (halt) begin
                        r_state    <= ST_FLUSH;
                        r_ptr      <= '0;
                        r_flushing <= 1'b1;
                    end else if (cpu_req) begin
                        r_state     <= ST_COMPARE;
                        r_tag       <= w_cpu_tag;
                        r_idx       <= w_cpu_idx;
                        r_wsel      <= cpu_addr[2 +: c_wsel_w];
                        r_we        <= cpu_we;
                        r_wdata     <= cpu_wdata;
                        r_refilled  <= 1'b0;
                        r_mem_wdata <= w_rd_data;
                        r_mem_addr  <= w_acc_victim
                                     ? {w_rd_tag, w_cpu_idx, {c_offset_w{1'b0}}}
                                     : {w_cpu_tag, w_cpu_idx, {c_offset_w{1'b0}}};
                    end
                end
                ST_COMPARE: begin
                    if (w_hit) begin
                        r_state <= ST_IDLE;
                    end else if (w_rd_valid && w_rd_dirty) begin
                        r_state  <= ST_WRITEBACK;
                        r_mem_wr <= 1'b1;
                        r_cnt    <= c_cnt_init;
                    end else begin
                        r_state  <= ST_ALLOCATE;
                        r_mem_rd <= 1'b1;
                        r_cnt    <= c_cnt_init;
                    end
                end
                ST_WRITEBACK: begin
                    if (!r_mem_wr) begin
                        r_mem_wr <= 1'b1;
                        r_cnt    <= c_cnt_init;
                    end else if (r_cnt == '0) begin
                        r_mem_wr <= 1'b0;
                        if (!r_flushing) begin
                            r_state    <= ST_ALLOCATE;
                            r_mem_addr <= {r_tag, r_idx, {c_offset_w{1'b0}}};
                        end else if (r_ptr == c_last_idx) begin
                            r_state     <= ST_DONE;
                            r_mem_flush <= 1'b1;
                        end else begin
                            r_state <= ST_FLUSH;
                            r_ptr   <= r_ptr + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ALLOCATE: begin
                    // Entered with the strobe low after a writeback: that
                    // cycle is the mandatory gap between strobes.
                    if (!r_mem_rd) begin
                        r_mem_rd <= 1'b1;
                        r_cnt    <= c_cnt_init;
                    end else if (r_cnt == '0) begin
                        r_mem_rd   <= 1'b0;
                        r_refilled <= 1'b1;
                        r_state    <= ST_COMPARE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (w_rd_valid && w_rd_dirty) begin
                        r_state     <= ST_WRITEBACK;
                        r_mem_addr  <= {w_rd_tag, r_ptr, {c_offset_w{1'b0}}};
                        r_mem_wdata <= w_rd_data;
                    end else if (r_ptr == c_last_idx) begin
                        r_state     <= ST_DONE;
                        r_mem_flush <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_mem_flush <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_ready = (r_state == ST_COMPARE) && w_hit;
    assign cpu_rdata = (cpu_ready && !r_we) ? w_word : '0;
    assign mem_addr  = r_mem_addr;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_mem_wdata;
    assign mem_flush = r_mem_flush;

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // The hit that follows a refill is not a first-pass hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == ST_COMPARE) begin
            if (!w_hit) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end else if (!r_refilled) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dcache_ctrl
// Brief    : Directed vector bench for dcache_ctrl with a block memory model.
// Revision : 1.0
// ============================================================================
module tb_dcache_ctrl;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 128;
    localparam int LINES   = 16;
    localparam int MEM_LAT = 2;

    logic               clk;
    logic               rst;
    logic               cpu_req;
    logic               cpu_we;
    logic [WORD_W-1:0]  cpu_addr;
    logic [WORD_W-1:0]  cpu_wdata;
    logic [WORD_W-1:0]  cpu_rdata;
    logic               cpu_ready;
    logic               halt;
    logic [WORD_W-1:0]  mem_addr;
    logic               mem_rd;
    logic               mem_wr;
    logic [BLOCK_W-1:0] mem_wdata;
    logic [BLOCK_W-1:0] mem_rdata;
    logic               mem_flush;
    logic [31:0]        hit_cnt;
    logic [31:0]        miss_cnt;

    dcache_ctrl #(
        .WORD_W  (WORD_W),
        .BLOCK_W (BLOCK_W),
        .LINES   (LINES),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .halt      (halt),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_flush (mem_flush),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [BLOCK_W-1:0] mem [256];
    assign mem_rdata = mem[mem_addr[11:4]];

    function automatic logic [BLOCK_W-1:0] blk(input int k);
        logic [BLOCK_W-1:0] b;
        for (int j = 0; j < 4; j++) begin
            b[BLOCK_W-1-j*32 -: 32] = 32'hC000_0000 | (32'(k) << 8) | 32'(j);
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Strobe monitor: shape checks plus the datamem write model.
    bit                 mon_skip;
    logic               p_rd, p_wr;
    logic [WORD_W-1:0]  p_addr;
    logic [BLOCK_W-1:0] p_wdata;
    int                 run;
    int                 rd_rises = 0;
    int                 wr_rises = 0;
    int                 ready_cnt = 0;
    logic [WORD_W-1:0]  wr_log_addr [$];
    logic [BLOCK_W-1:0] wr_log_data [$];

    always @(negedge clk) begin
        if (!mon_skip) begin
            if (cpu_ready) ready_cnt++;
            if ((mem_rd || mem_wr) && !(p_rd || p_wr)) begin
                check("strobe_addr_setup", mem_addr, p_addr);
                if (mem_wr) check("strobe_data_setup", mem_wdata, p_wdata);
                check("strobe_exclusive", 128'(mem_rd && mem_wr), 128'd0);
                if (mem_rd) rd_rises++;
                if (mem_wr) wr_rises++;
                run = 1;
            end else if (mem_rd || mem_wr) begin
                check("strobe_same_kind", {mem_rd, mem_wr}, {p_rd, p_wr});
                check("strobe_addr_hold", mem_addr, p_addr);
                run++;
            end else if (p_rd || p_wr) begin
                check("strobe_len", 128'(run), 128'(MEM_LAT));
                if (p_wr) begin
                    mem[p_addr[11:4]] = p_wdata;
                    wr_log_addr.push_back(p_addr);
                    wr_log_data.push_back(p_wdata);
                end
            end
        end
        p_rd    = mem_skip_val(mem_rd);
        p_wr    = mem_skip_val(mem_wr);
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
    end

    function automatic logic mem_skip_val(input logic v);
        return mon_skip ? 1'b0 : v;
    endfunction

    task automatic do_reset();
        mon_skip = 1'b1;
        rst      = 1'b1;
        cpu_req  = 1'b0;
        halt     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mon_skip = 1'b0;
    endtask

    task automatic access(input logic we, input logic [WORD_W-1:0] addr, input logic [WORD_W-1:0] wdata,
                          output logic [WORD_W-1:0] rdata, output int lat);
        bit done;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        lat   = 0;
        done  = 1'b0;
        rdata = '0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (cpu_ready) begin
                done  = 1'b1;
                rdata = cpu_rdata;
            end
        end
        cpu_req = 1'b0;
        if (!done) lat = -1;
    endtask

    typedef struct {
        logic               we;
        logic [WORD_W-1:0]  addr;
        logic [WORD_W-1:0]  wdata;
        logic [WORD_W-1:0]  exp_rdata;
        int                 kind;       // 0 hit, 1 clean miss, 2 dirty miss
        logic [WORD_W-1:0]  wb_addr;
        logic [BLOCK_W-1:0] wb_data;
        string              name;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [WORD_W-1:0] rdata;
        int lat, r0, w0, n0;
        bit seen;

        vecs[0] = '{1'b0, 32'h00,  32'h0,        32'h11111111, 1, 32'h0, 128'h0, "ld00_miss"};
        vecs[1] = '{1'b0, 32'h0C,  32'h0,        32'h44444444, 0, 32'h0, 128'h0, "ld0c_hit"};
        vecs[2] = '{1'b1, 32'h04,  32'hDEADBEEF, 32'h0,        0, 32'h0, 128'h0, "st04_hit"};
        vecs[3] = '{1'b0, 32'h104, 32'h0,        32'hC0001001, 2, 32'h0,
                    128'h11111111_DEADBEEF_33333333_44444444, "ld104_dirty"};
        vecs[4] = '{1'b0, 32'h04,  32'h0,        32'hDEADBEEF, 1, 32'h0, 128'h0, "ld04_refetch"};
        vecs[5] = '{1'b1, 32'h18,  32'h00001234, 32'h0,        1, 32'h0, 128'h0, "st18_miss"};
        vecs[6] = '{1'b1, 32'h30,  32'hCAFEF00D, 32'h0,        1, 32'h0, 128'h0, "st30_miss"};
        vecs[7] = '{1'b0, 32'h18,  32'h0,        32'h00001234, 0, 32'h0, 128'h0, "ld18_hit"};

        for (int k = 0; k < 256; k++) mem[k] = blk(k);
        mem[0] = 128'h11111111_22222222_33333333_44444444;
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_wdata = '0; run = 0;

        mon_skip = 1'b1;
        rst = 1'b1; cpu_req = 1'b0; halt = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cpu_ready", 128'(cpu_ready), 128'd0);
        check("rst_cpu_rdata", 128'(cpu_rdata), 128'd0);
        check("rst_mem_rd",    128'(mem_rd),    128'd0);
        check("rst_mem_wr",    128'(mem_wr),    128'd0);
        check("rst_mem_flush", 128'(mem_flush), 128'd0);
        check("rst_mem_addr",  128'(mem_addr),  128'd0);
        check("rst_mem_wdata", mem_wdata,       128'd0);
        check("rst_hit_cnt",   128'(hit_cnt),   128'd0);
        check("rst_miss_cnt",  128'(miss_cnt),  128'd0);
        rst = 1'b0;
        @(negedge clk);
        mon_skip = 1'b0;

        for (int i = 0; i < 8; i++) begin
            r0 = rd_rises;
            w0 = wr_rises;
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rdata, lat);
            case (vecs[i].kind)
                0: begin
                    check({vecs[i].name, "_lat"}, 128'(lat), 128'd1);
                    check({vecs[i].name, "_rd"},  128'(rd_rises - r0), 128'd0);
                    check({vecs[i].name, "_wr"},  128'(wr_rises - w0), 128'd0);
                end
                1: begin
                    check({vecs[i].name, "_lat"}, 128'(lat), 128'(MEM_LAT + 2));
                    check({vecs[i].name, "_rd"},  128'(rd_rises - r0), 128'd1);
                    check({vecs[i].name, "_wr"},  128'(wr_rises - w0), 128'd0);
                end
                default: begin
                    check({vecs[i].name, "_done"}, 128'(lat > 0), 128'd1);
                    check({vecs[i].name, "_rd"},   128'(rd_rises - r0), 128'd1);
                    check({vecs[i].name, "_wr"},   128'(wr_rises - w0), 128'd1);
                    check({vecs[i].name, "_wbaddr"},
                          128'(wr_log_addr.size() > 0 ? wr_log_addr[wr_log_addr.size()-1] : 32'hFFFF_FFFF),
                          128'(vecs[i].wb_addr));
                    check({vecs[i].name, "_wbdata"},
                          wr_log_data.size() > 0 ? wr_log_data[wr_log_data.size()-1] : '1,
                          vecs[i].wb_data);
                end
            endcase
            if (!vecs[i].we) check({vecs[i].name, "_rdata"}, 128'(rdata), 128'(vecs[i].exp_rdata));
        end

`ifdef DCACHE_STATS_EN
        check("stats_hits",   128'(hit_cnt),  128'd3);
        check("stats_misses", 128'(miss_cnt), 128'd5);
`else
        check("stats_hits_tied",   128'(hit_cnt),  128'd0);
        check("stats_misses_tied", 128'(miss_cnt), 128'd0);
`endif

        // Halt flush: lines 1 and 3 are dirty, line 0 was refilled clean.
        w0 = wr_rises;
        n0 = wr_log_addr.size();
        @(negedge clk);
        halt = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = mem_flush;
        end
        check("flush_done", 128'(seen), 128'd1);
        check("flush_wr_count", 128'(wr_rises - w0), 128'd2);
        check("flush_wb0_addr", 128'(wr_log_addr.size() > n0 ? wr_log_addr[n0] : 32'hFFFF_FFFF), 128'h10);
        check("flush_wb0_data", wr_log_data.size() > n0 ? wr_log_data[n0] : '1,
              128'hC0000100_C0000101_00001234_C0000103);
        check("flush_wb1_addr", 128'(wr_log_addr.size() > n0+1 ? wr_log_addr[n0+1] : 32'hFFFF_FFFF), 128'h30);
        check("flush_wb1_data", wr_log_data.size() > n0+1 ? wr_log_data[n0+1] : '1,
              128'hCAFEF00D_C0000301_C0000302_C0000303);
        repeat (5) @(negedge clk);
        check("flush_held", 128'(mem_flush), 128'd1);
        halt = 1'b0;

        // Halt and request in the same cycle: halt wins, no completion.
        do_reset();
        ready_cnt = 0;
        w0 = wr_rises;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; halt = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = mem_flush;
        end
        repeat (4) @(negedge clk);
        check("halt_req_flush", 128'(seen), 128'd1);
        check("halt_req_no_ready", 128'(ready_cnt), 128'd0);
        check("halt_req_no_wr", 128'(wr_rises - w0), 128'd0);
        cpu_req = 1'b0; halt = 1'b0;

        // Reset in the middle of a refill.
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = mem_rd;
        end
        check("alloc_reached", 128'(seen), 128'd1);
        mon_skip = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_alloc_mem_rd", 128'(mem_rd), 128'd0);
        check("rst_alloc_mem_wr", 128'(mem_wr), 128'd0);
        check("rst_alloc_ready",  128'(cpu_ready), 128'd0);
        check("rst_alloc_hits",   128'(hit_cnt), 128'd0);
        check("rst_alloc_misses", 128'(miss_cnt), 128'd0);
        cpu_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        mon_skip = 1'b0;
        r0 = rd_rises;
        access(1'b0, 32'h40, 32'h0, rdata, lat);
        check("reload40_lat",   128'(lat), 128'(MEM_LAT + 2));
        check("reload40_rd",    128'(rd_rises - r0), 128'd1);
        check("reload40_rdata", 128'(rdata), 128'hC0000400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
